// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer between instruction memory and the IR.
// Reads the word at the PC (or at a jump target) and tolerates any memory latency.
// The word is then presented on InstEntrada with a one-cycle IRIn strobe, and the PC advances.
//
// Ports:
//   Clock, Resetn        clock, asynchronous active-low reset
//   FetchReq             fetch request from the control unit (sampled in IDLE only)
//   JumpEn, JumpAddr     load PC from JumpAddr (IDLE only)
//   MemAddr, MemRd       registered read address and one-cycle read strobe
//   MemData, MemReady    returned instruction word and its valid flag
//   InstEntrada, IRIn    registered instruction and IR load pulse
//   PC, Busy, Fault      program counter, not-IDLE flag, memory timeout flag
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.
// An aborted WAIT sets a sticky Fault.

module instr_fetch #(
    parameter int unsigned n        = 10,
    parameter int unsigned A        = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         FetchReq,
    input  logic         JumpEn,
    input  logic [A-1:0] JumpAddr,
    output logic [A-1:0] MemAddr,
    output logic         MemRd,
    input  logic [n-1:0] MemData,
    input  logic         MemReady,
    output logic [n-1:0] InstEntrada,
    output logic         IRIn,
    output logic [A-1:0] PC,
    output logic         Busy,
    output logic         Fault
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOAD} state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   pc_q, pc_d;
    logic [A-1:0]   mem_addr_q, mem_addr_d;
    logic [n-1:0]   inst_q, inst_d;
    logic           mem_rd_q, mem_rd_d;
    logic           ir_in_q, ir_in_d;
    logic           busy_q, busy_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic             expired;

    assign expired = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // State and registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= A'(RESET_PC);
            mem_addr_q <= A'(RESET_PC);
            inst_q     <= '0;
            mem_rd_q   <= 1'b0;
            ir_in_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            inst_q     <= inst_d;
            mem_rd_q   <= mem_rd_d;
            ir_in_q    <= ir_in_d;
            busy_q     <= busy_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (FetchReq) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (MemReady) begin
                    state_d = S_LOAD;
`ifdef FETCH_TIMEOUT_EN
                end else if (expired) begin
                    state_d = S_IDLE;
`endif
                end
            end
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; strobes follow the state being entered so they align with it
    always_comb begin
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        inst_d     = inst_q;
        mem_rd_d   = (state_d == S_ISSUE);
        ir_in_d    = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        if (state_d == S_ISSUE) fault_d = 1'b0;
        if (state_q == S_ISSUE) wait_cnt_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (JumpEn) pc_d = JumpAddr;
                // A simultaneous jump redirects this fetch to the jump target
                if (FetchReq) mem_addr_d = JumpEn ? JumpAddr : pc_q;
            end
            S_WAIT: begin
                if (MemReady) begin
                    inst_d = MemData;
                    pc_d   = pc_q + A'(1);
`ifdef FETCH_TIMEOUT_EN
                end else if (expired) begin
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end
            default: ;
        endcase
    end

    assign MemAddr     = mem_addr_q;
    assign MemRd       = mem_rd_q;
    assign InstEntrada = inst_q;
    assign IRIn        = ir_in_q;
    assign PC          = pc_q;
    assign Busy        = busy_q;
`ifdef FETCH_TIMEOUT_EN
    assign Fault       = fault_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign Fault          = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that feeds the instruction register. On request from the control unit it reads the instruction word at the program counter from instruction memory, tolerating variable memory latency. It then presents the word on `InstEntrada` with a one-cycle `IRIn` load strobe and advances the PC. It sits between instruction memory and the instruction register, and is the writer side of the IR load interface.

## Interface
Parameters:
- `n`, 10, instruction width in bits; equals the IR width.
- `A`, 8, program-counter and memory-address width.
- `RESET_PC`, 0, PC value after reset.
- `TIMEOUT`, 15, maximum WAIT cycles; used only with `FETCH_TIMEOUT_EN`.

Ports:
- `Clock`, in, 1, single clock; all state changes on the rising edge.
- `Resetn`, in, 1, asynchronous, active-low reset.
- `FetchReq`, in, 1, control unit requests the next instruction.
- `JumpEn`, in, 1, load the PC from `JumpAddr`.
- `JumpAddr`, in, A, jump target.
- `MemAddr`, out, A, registered read address to instruction memory.
- `MemRd`, out, 1, one-cycle read strobe.
- `MemData`, in, n, instruction word from memory.
- `MemReady`, in, 1, `MemData` is valid this cycle.
- `InstEntrada`, out, n, registered instruction to the IR.
- `IRIn`, out, 1, IR load enable; a one-cycle pulse.
- `PC`, out, A, current program counter.
- `Busy`, out, 1, high when state is not IDLE.
- `Fault`, out, 1, memory timeout flag.

## Operation
- FSM states and transitions:
  - IDLE: `MemRd`=0.
    - `JumpEn`=1 loads PC <= `JumpAddr`.
    - `FetchReq`=1 moves to ISSUE with `MemAddr` <= (`JumpEn` ? `JumpAddr` : PC).
    - When `JumpEn` and `FetchReq` are both high, the jump is applied and the fetch reads the jump target.
  - ISSUE: `MemRd`=1 for exactly one cycle; `MemReady` is ignored; next state WAIT.
  - WAIT: `MemRd`=0. On `MemReady`=1:
    - `InstEntrada` <= `MemData`.
    - PC <= PC+1, modulo 2^A; 2^A−1 wraps to 0.
    - Next state LOAD.
  - LOAD: `IRIn`=1 with `InstEntrada` stable; next state IDLE.
- `FetchReq` and `JumpEn` are ignored outside IDLE. There is no request queuing; the control unit re-asserts after `Busy` falls.
- `InstEntrada` holds its last value outside LOAD.
- Reset values (asynchronous, immediate): state IDLE; PC=`RESET_PC`; `MemAddr`=`RESET_PC`; `MemRd`=0; `IRIn`=0; `InstEntrada`=0; `Busy`=0; `Fault`=0.
- Reset asserted mid-fetch aborts the fetch: no `IRIn` pulse and no PC increment. A late `MemReady` after reset release is ignored in IDLE.

## Timing
- Cycle 0: IDLE, `FetchReq`=1 sampled.
- Cycle 1: ISSUE, `MemRd`=1, `MemAddr` valid.
- Cycle 2: WAIT; `MemReady`=1 here is the zero-wait case.
- Cycle 3: LOAD, `IRIn`=1; the IR captures at the rising edge ending cycle 3.
- Minimum latency is 3 cycles from `FetchReq` sampled to the `IRIn` pulse; each extra WAIT cycle adds 1.
- Back-to-back fetches take 4 cycles per instruction (IDLE, ISSUE, WAIT, LOAD).
- `MemAddr` is stable from ISSUE until the next ISSUE.
- The PC value shown in LOAD is already incremented.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A WAIT counter clears on entry to WAIT.
  - If `TIMEOUT` consecutive WAIT cycles pass without `MemReady`, the FSM returns to IDLE and sets `Fault`=1.
  - The aborted fetch leaves PC unchanged and produces no `IRIn` pulse.
  - `Fault` is sticky and clears on the next entry to ISSUE.
  - `MemReady` in the same cycle the count expires wins: the fetch completes normally.
- `FETCH_TIMEOUT_EN` undefined:
  - WAIT persists indefinitely.
  - `Fault` is tied to 0.
  - No counter logic is generated.

## Test plan
- Reset, then `FetchReq` pulse with a memory model returning 10'h2A5 the cycle after `MemRd` -> `MemRd` high in cycle 1 with `MemAddr`=0; `IRIn` high only in cycle 3; `InstEntrada`=10'h2A5; PC=1.
- Memory with 4 wait cycles -> `IRIn` in cycle 7, `Busy` high in cycles 1–7, `MemRd` high only in cycle 1.
- `JumpEn`=1, `JumpAddr`=8'hFF together with `FetchReq` -> `MemAddr`=8'hFF; PC wraps to 8'h00 after the fetch.
- `Resetn` pulsed low during WAIT -> outputs return to reset values immediately; a later `MemReady` produces no `IRIn` pulse; PC=`RESET_PC`.
- `FetchReq` held high continuously for 12 cycles -> exactly 3 `IRIn` pulses, fetching addresses 0, 1, 2.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT`=15 and memory never ready -> `Fault`=1 after 15 WAIT cycles, no `IRIn`, PC unchanged; the next `FetchReq` clears `Fault` in ISSUE.
